// File: rtl/gs_bus_pkg.sv
// Shared constants for the control-register bus master: register addresses,
// default-configuration table and FSM state encoding.
package gs_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT_WR = 2'd1,
    FIFO_WR = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SEQ_W    = 16;
  localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;
  localparam int unsigned INIT_LEN = 9;

  localparam logic [ADDR_W-1:0] REG_ADDR_0 = 64'd0;
  localparam logic [ADDR_W-1:0] REG_ADDR_1 = 64'd1;
  localparam logic [ADDR_W-1:0] REG_ADDR_2 = 64'd2;
  localparam logic [ADDR_W-1:0] REG_ADDR_3 = 64'd3;
  localparam logic [ADDR_W-1:0] REG_ADDR_4 = 64'd4;
  localparam logic [ADDR_W-1:0] REG_ADDR_5 = 64'd5;
  localparam logic [ADDR_W-1:0] REG_ADDR_6 = 64'd6;
  localparam logic [ADDR_W-1:0] REG_ADDR_7 = 64'd7;
  localparam logic [ADDR_W-1:0] REG_ADDR_8 = 64'd8;

  localparam logic [DATA_W-1:0] REG_DEF_0 = 32'h0000_0000;
  localparam logic [DATA_W-1:0] REG_DEF_1 = 32'h0000_0000;
  localparam logic [DATA_W-1:0] REG_DEF_2 = 32'h0000_0000;
  localparam logic [DATA_W-1:0] REG_DEF_3 = 32'h0000_0000;
  localparam logic [DATA_W-1:0] REG_DEF_4 = 32'h0000_0000;
  localparam logic [DATA_W-1:0] REG_DEF_5 = 32'h0000_0001;
  localparam logic [DATA_W-1:0] REG_DEF_6 = 32'h0000_0001;
  localparam logic [DATA_W-1:0] REG_DEF_7 = 32'h0000_8000;
  localparam logic [DATA_W-1:0] REG_DEF_8 = 32'h0000_0000;

  function automatic logic [ADDR_W-1:0] init_addr(input logic [3:0] idx);
    logic [ADDR_W-1:0] a;
    case (idx)
      4'd0:    a = REG_ADDR_0;
      4'd1:    a = REG_ADDR_1;
      4'd2:    a = REG_ADDR_2;
      4'd3:    a = REG_ADDR_3;
      4'd4:    a = REG_ADDR_4;
      4'd5:    a = REG_ADDR_5;
      4'd6:    a = REG_ADDR_6;
      4'd7:    a = REG_ADDR_7;
      4'd8:    a = REG_ADDR_8;
      default: a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [DATA_W-1:0] init_data(input logic [3:0] idx);
    logic [DATA_W-1:0] d;
    case (idx)
      4'd0:    d = REG_DEF_0;
      4'd1:    d = REG_DEF_1;
      4'd2:    d = REG_DEF_2;
      4'd3:    d = REG_DEF_3;
      4'd4:    d = REG_DEF_4;
      4'd5:    d = REG_DEF_5;
      4'd6:    d = REG_DEF_6;
      4'd7:    d = REG_DEF_7;
      4'd8:    d = REG_DEF_8;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gs_bus_fifo.sv
// Request queue for the bus master: power-of-two depth, one {addr,data} entry
// per request, head visible combinationally from registered storage.
module gs_bus_fifo
  import gs_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic             bus_clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge bus_clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge bus_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gs_bus_master.sv
// Bus master for the control register block: serialises queued write requests
// and the default-configuration sequence onto a single registered write strobe.
module gs_bus_master
  import gs_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              bus_clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              init_start,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic [SEQ_W-1:0]  bus_gpreg,
  output logic              busy,
  output logic              init_done
);

  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  logic [3:0]         init_idx;
  logic               init_busy;
  logic [SEQ_W-1:0]   seq_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               ready_q;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  logic               arb_point;
  logic               init_go;
  logic               init_fin;
  logic               fifo_go;

  assign req_ready = ready_q && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_pop  = arb_point && fifo_go;
  assign busy      = (state != IDLE) || !fifo_empty;

  gs_bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .bus_clk   (bus_clk),
    .nrst      (nrst),
    .push      (fifo_push),
    .push_data ({req_addr, req_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // init_busy spans pending, running and the final gap; init_idx==INIT_LEN
  // marks that every table write has issued and only init_done remains.
  always_comb begin
    arb_point = 1'b0;
    case (state)
      IDLE:             arb_point = 1'b1;
      INIT_WR, FIFO_WR: arb_point = (GAP_CYCLES == 0);
      GAP:              arb_point = (gap_cnt == GAP_LAST);
      default:          arb_point = 1'b0;
    endcase
    init_go  = init_busy && (init_idx != 4'(INIT_LEN));
    init_fin = init_busy && (init_idx == 4'(INIT_LEN));
    fifo_go  = !init_go && !fifo_empty;
  end

  always_ff @(posedge bus_clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      init_busy <= 1'b0;
      init_idx  <= '0;
      gap_cnt   <= '0;
      seq_cnt   <= '0;
      ready_q   <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      bus_gpreg <= '0;
      init_done <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      init_done <= 1'b0;
      if (init_start && !init_busy) init_busy <= 1'b1;

      if (arb_point) begin
        if (init_fin) begin
          init_busy <= 1'b0;
          init_idx  <= '0;
          init_done <= 1'b1;
        end
        if (init_go) begin
          state     <= INIT_WR;
          bus_valid <= 1'b1;
          bus_addr  <= init_addr(init_idx);
          bus_data  <= init_data(init_idx);
          bus_gpreg <= seq_cnt;
          seq_cnt   <= seq_cnt + SEQ_W'(1);
          init_idx  <= init_idx + 4'd1;
        end else if (fifo_go) begin
          state     <= FIFO_WR;
          bus_valid <= 1'b1;
          bus_addr  <= fifo_head[ENTRY_W-1:DATA_W];
          bus_data  <= fifo_head[DATA_W-1:0];
          bus_gpreg <= seq_cnt;
          seq_cnt   <= seq_cnt + SEQ_W'(1);
        end else begin
          state     <= IDLE;
          bus_valid <= 1'b0;
        end
      end else if (state == INIT_WR || state == FIFO_WR) begin
        state     <= GAP;
        gap_cnt   <= '0;
        bus_valid <= 1'b0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gs_bus_master.sv
// Scoreboard bench for gs_bus_master: stimulus queues expected bus writes,
// a negedge monitor pops and compares each strobe.
module tb_gs_bus_master;

  localparam int GAP = 1;

  logic        bus_clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        init_start = 1'b0;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [31:0] bus_data;
  logic [15:0] bus_gpreg;
  logic        busy;
  logic        init_done;

  gs_bus_master #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .bus_clk(bus_clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .init_start(init_start),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_gpreg(bus_gpreg), .busy(busy), .init_done(init_done)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
    logic [15:0] g;
  } exp_t;

  exp_t        exp_q[$];
  int          strobe_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] model_seq = '0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          exp_done = 0;
  bit          saw_stall = 0;
  logic [31:0] init_tab [0:8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h8000, 32'h0};

  always @(posedge bus_clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void expect_write(input logic [63:0] a, input logic [31:0] d);
    exp_q.push_back({a, d, model_seq});
    model_seq = model_seq + 16'd1;
  endfunction

  function automatic void expect_init();
    for (int i = 0; i < 9; i++) expect_write(64'(i), init_tab[i]);
  endfunction

  // Monitor: every strobe must match the head of the expected queue.
  logic [63:0] last_a = '0;
  logic [31:0] last_d = '0;
  int          last_strobe = -100;
  always @(negedge bus_clk) begin
    if (!nrst) begin
      last_a = '0;
      last_d = '0;
      last_strobe = -100;
    end else begin
      if (bus_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", bus_addr, 64'hDEAD_0000_0000_0000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bus_addr", bus_addr, e.a);
          chk("bus_data", {32'h0, bus_data}, {32'h0, e.d});
          chk("bus_gpreg", {48'h0, bus_gpreg}, {48'h0, e.g});
          last_a = e.a;
          last_d = e.d;
        end
        chk("strobe_spacing_min", 64'(cyc - last_strobe >= GAP + 1), 64'd1);
        last_strobe = cyc;
        strobe_q.push_back(cyc);
      end else begin
        chk("hold_addr", bus_addr, last_a);
        chk("hold_data", {32'h0, bus_data}, {32'h0, last_d});
      end
      if (init_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_req(input logic [63:0] a, input logic [31:0] d, input bit auto_exp, output int acc);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    acc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge bus_clk);
      if (req_ready) begin
        @(posedge bus_clk);
        #1;
        acc = cyc;
        break;
      end else begin
        saw_stall = 1;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      chk("push_timeout", 64'd0, 64'd1);
      @(posedge bus_clk);
      #1;
    end else if (auto_exp) begin
      expect_write(a, d);
    end
  endtask

  task automatic pulse_init();
    init_start = 1'b1;
    @(posedge bus_clk);
    #1;
    init_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int quiet;
    bit ok;
    quiet = 0;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge bus_clk);
      #1;
      if (exp_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, "_addr"}, bus_addr, 64'd0);
    chk({tag, "_data"}, {32'h0, bus_data}, 64'd0);
    chk({tag, "_gpreg"}, {48'h0, bus_gpreg}, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    int acc;
    int n_rand;

    // Reset state
    repeat (3) @(posedge bus_clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(posedge bus_clk);
    #1;
    chk("req_ready_after_release", 64'(req_ready), 64'd1);

    // Single request, minimum latency, first sequence number 0
    strobe_q.delete();
    push_req(64'd2, 32'h1234, 1, acc);
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_idle(50);
    chk("single_count", 64'(strobe_q.size()), 64'd1);
    if (strobe_q.size() > 0) chk("single_latency", 64'(strobe_q[0]), 64'(acc + 1));

    // Init running while 5 requests queue up behind it; FIFO fills and stalls
    strobe_q.delete();
    saw_stall = 0;
    pulse_init();
    expect_init();
    exp_done++;
    for (int i = 0; i < 5; i++) push_req({$urandom, $urandom}, $urandom, 1, acc);
    chk("req_ready_dropped_on_full", 64'(saw_stall), 64'd1);
    wait_idle(200);
    chk("b2b_count", 64'(strobe_q.size()), 64'd14);
    for (int i = 1; i < strobe_q.size(); i++)
      chk("b2b_spacing", 64'(strobe_q[i] - strobe_q[i-1]), 64'(GAP + 1));

    // Init with a second init_start mid-sequence
    strobe_q.delete();
    pulse_init();
    expect_init();
    exp_done++;
    repeat (6) @(posedge bus_clk);
    #1;
    pulse_init();
    wait_idle(200);
    chk("init_write_count", 64'(strobe_q.size()), 64'd9);
    if (strobe_q.size() > 0)
      chk("init_done_timing", 64'(done_cyc), 64'(strobe_q[strobe_q.size()-1] + GAP + 1));
    chk("init_done_count_a", 64'(done_cnt), 64'(exp_done));

    // init_start during a FIFO write: that write, then init, then the queued entry
    begin
      logic [63:0] b_a;
      logic [31:0] b_d;
      b_a = {$urandom, $urandom};
      b_d = $urandom;
      push_req({$urandom, $urandom}, $urandom, 1, acc);
      push_req(b_a, b_d, 0, acc);
      chk("fifo_write_in_progress", 64'(bus_valid), 64'd1);
      pulse_init();
      expect_init();
      expect_write(b_a, b_d);
      exp_done++;
      wait_idle(200);
    end

    // Randomised traffic
    n_rand = 40;
    for (int i = 0; i < n_rand; i++) begin
      push_req({$urandom, $urandom}, $urandom, 1, acc);
      repeat ($urandom_range(0, 3)) @(posedge bus_clk);
      #1;
    end
    wait_idle(400);

    // Sequence counter wrap
    force dut.seq_cnt = 16'hFFFF;
    @(posedge bus_clk);
    #1;
    release dut.seq_cnt;
    model_seq = 16'hFFFF;
    push_req(64'h1111_2222_3333_4444, 32'hAAAA_5555, 1, acc);
    push_req(64'h5555_6666_7777_8888, 32'h5555_AAAA, 1, acc);
    wait_idle(50);

    // Reset during init write 4
    pulse_init();
    expect_init();
    begin
      bit hit;
      hit = 0;
      for (int n = 0; n < 60; n++) begin
        @(posedge bus_clk);
        #1;
        if (bus_valid && bus_addr == 64'd4) begin
          hit = 1;
          break;
        end
      end
      chk("reached_init_write_4", 64'(hit), 64'd1);
    end
    nrst = 1'b0;
    #1;
    check_reset_outputs("midinit_reset");
    exp_q.delete();
    model_seq = '0;
    strobe_q.delete();
    repeat (2) @(posedge bus_clk);
    #1;
    nrst = 1'b1;
    @(posedge bus_clk);
    #1;
    chk("req_ready_after_rerelease", 64'(req_ready), 64'd1);
    repeat (20) @(posedge bus_clk);
    #1;
    chk("no_strobe_after_reset", 64'(strobe_q.size()), 64'd0);
    push_req(64'h0000_0000_0000_00AB, 32'hCAFE_F00D, 1, acc);
    wait_idle(50);
    chk("post_reset_write_count", 64'(strobe_q.size()), 64'd1);
    chk("init_done_count", 64'(done_cnt), 64'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
